// File: rtl/neuron_operand_loader_if.sv
`default_nettype none
// ============================================================================
// neuron_operand_loader_if : word stream in, held operand bundle out
// Rev 1.0
// ============================================================================
interface neuron_operand_loader_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              reuse_w;
  logic              clear;
  logic [DATA_W-1:0] x1;
  logic [DATA_W-1:0] x2;
  logic [DATA_W-1:0] w1;
  logic [DATA_W-1:0] w2;
  logic [DATA_W-1:0] b;
  logic              op_valid;
  logic              op_ready;
  logic              busy;

  modport slave (
    input  s_data, s_valid, reuse_w, clear, op_ready,
    output s_ready, x1, x2, w1, w2, b, op_valid, busy
  );

  modport master (
    output s_data, s_valid, reuse_w, clear, op_ready,
    input  s_ready, x1, x2, w1, w2, b, op_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/neuron_operand_loader.sv
`default_nettype none
// ============================================================================
// neuron_operand_loader : assembles x1,x2,w1,w2,b words into a held bundle
// Rev 1.0
// ============================================================================
module neuron_operand_loader #(
  parameter int DATA_W = 32
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  neuron_operand_loader_if.slave        s_if
);
  localparam logic [2:0] C_LAST_FULL  = 3'd4;
  localparam logic [2:0] C_LAST_REUSE = 3'd1;

  logic [2:0]        r_idx;
  logic              r_mode_reuse;
  logic [DATA_W-1:0] r_st_x1, r_st_x2, r_st_w1, r_st_w2, r_st_b;
  logic [DATA_W-1:0] r_x1, r_x2, r_w1, r_w2, r_b;
  logic              r_op_valid;

  logic              w_at_last;
  logic              w_s_ready;
  logic              w_accept;

  // idx 0 is never a last index, so the stale mode bit is harmless there.
  assign w_at_last = (r_idx == (r_mode_reuse ? C_LAST_REUSE : C_LAST_FULL));

  // Integration note: s_ready is combinational from op_ready at the last index.
  assign w_s_ready = !(w_at_last && r_op_valid && !s_if.op_ready);
  assign w_accept  = s_if.s_valid && w_s_ready && !s_if.clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= 3'd0;
      r_mode_reuse <= 1'b0;
      r_st_x1      <= '0;
      r_st_x2      <= '0;
      r_st_w1      <= '0;
      r_st_w2      <= '0;
      r_st_b       <= '0;
      r_x1         <= '0;
      r_x2         <= '0;
      r_w1         <= '0;
      r_w2         <= '0;
      r_b          <= '0;
      r_op_valid   <= 1'b0;
    end else if (s_if.clear) begin
      r_idx      <= 3'd0;
      r_op_valid <= 1'b0;
    end else begin
      if (r_op_valid && s_if.op_ready) begin
        r_op_valid <= 1'b0;
      end
      if (w_accept) begin
        case (r_idx)
          3'd0: begin
            r_st_x1      <= s_if.s_data;
            r_mode_reuse <= s_if.reuse_w;
          end
          3'd1:    r_st_x2 <= s_if.s_data;
          3'd2:    r_st_w1 <= s_if.s_data;
          3'd3:    r_st_w2 <= s_if.s_data;
          3'd4:    r_st_b  <= s_if.s_data;
          default: ;
        endcase
        if (w_at_last) begin
          r_idx      <= 3'd0;
          r_op_valid <= 1'b1;
          r_x1       <= r_st_x1;
          if (r_mode_reuse) begin
            r_x2 <= s_if.s_data;
            r_w1 <= r_st_w1;
            r_w2 <= r_st_w2;
            r_b  <= r_st_b;
          end else begin
            r_x2 <= r_st_x2;
            r_w1 <= r_st_w1;
            r_w2 <= r_st_w2;
            r_b  <= s_if.s_data;
          end
        end else begin
          r_idx <= r_idx + 3'd1;
        end
      end
    end
  end

  assign s_if.s_ready  = w_s_ready;
  assign s_if.x1       = r_x1;
  assign s_if.x2       = r_x2;
  assign s_if.w1       = r_w1;
  assign s_if.w2       = r_w2;
  assign s_if.b        = r_b;
  assign s_if.op_valid = r_op_valid;
  assign s_if.busy     = (r_idx != 3'd0);
endmodule
`default_nettype wire

// File: tb/tb_neuron_operand_loader.sv
`default_nettype none
// ============================================================================
// tb_neuron_operand_loader : table-driven frames with a bundle scoreboard
// Rev 1.0
// ============================================================================
module tb_neuron_operand_loader;
  typedef struct packed {
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] b;
  } bundle_t;

  typedef struct {
    logic        reuse;
    int          n;
    logic [31:0] w[5];
    bundle_t     exp;
  } vec_t;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  int      n_checks = 0;
  int      n_errors = 0;
  bundle_t sb[$];
  vec_t    tbl[6];

  neuron_operand_loader_if #(.DATA_W(32)) bus();
  neuron_operand_loader #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .s_if(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input int n,
                              input logic [31:0] a0, a1, a2, a3, a4,
                              input logic [31:0] e0, e1, e2, e3, e4);
    vec_t v;
    v.reuse = r;
    v.n     = n;
    v.w     = '{a0, a1, a2, a3, a4};
    v.exp   = '{e0, e1, e2, e3, e4};
    return v;
  endfunction

  // Each negedge with op_valid && op_ready is one bundle consumed at the next edge.
  always @(negedge clk) begin
    if (rst_n && bus.op_valid && bus.op_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_bundle: got x1=%h with empty scoreboard", bus.x1);
      end else begin
        bundle_t e;
        e = sb.pop_front();
        chk("bundle_x1", bus.x1, e.x1);
        chk("bundle_x2", bus.x2, e.x2);
        chk("bundle_w1", bus.w1, e.w1);
        chk("bundle_w2", bus.w2, e.w2);
        chk("bundle_b",  bus.b,  e.b);
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic r);
    int   n;
    logic ok;
    n = 0;
    bus.s_data  = d;
    bus.reuse_w = r;
    bus.s_valid = 1'b1;
    forever begin
      @(negedge clk);
      ok = bus.s_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      chk($sformatf("busy_w%0d", i), {31'd0, bus.busy}, (i != 0) ? 32'd1 : 32'd0);
      send(v.w[i], (i == 0) ? v.reuse : ~v.reuse);
    end
    sb.push_back(v.exp);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  task automatic clear_cycle(input logic v, input logic [31:0] d);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.clear   = 1'b1;
    @(posedge clk);
    #1;
    bus.clear   = 1'b0;
    bus.s_valid = 1'b0;
  endtask

  initial begin
    bundle_t bb;
    bus.s_data   = '0;
    bus.s_valid  = 1'b0;
    bus.reuse_w  = 1'b0;
    bus.clear    = 1'b0;
    bus.op_ready = 1'b1;

    tbl[0] = mk(1'b1, 2, 32'd11, 32'd12, 0, 0, 0, 32'd11, 32'd12, 0, 0, 0);
    tbl[1] = mk(1'b0, 5, 32'd5, -32'sd3, 32'd2, 32'd4, -32'sd7,
                32'd5, -32'sd3, 32'd2, 32'd4, -32'sd7);
    tbl[2] = mk(1'b1, 2, 32'd10, 32'd20, 0, 0, 0,
                32'd10, 32'd20, 32'd2, 32'd4, -32'sd7);
    tbl[3] = mk(1'b0, 5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd1, 32'd0,
                32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd1, 32'd0);
    tbl[4] = mk(1'b1, 2, 32'd3, 32'd4, 0, 0, 0, 32'd3, 32'd4, 32'h7FFF_FFFF, 32'd1, 32'd0);
    tbl[5] = mk(1'b0, 5, 32'd5, -32'sd3, 32'd2, 32'd4, -32'sd7,
                32'd5, -32'sd3, 32'd2, 32'd4, -32'sd7);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x1", bus.x1, 32'd0);
    chk("rst_b", bus.b, 32'd0);
    chk("rst_op_valid", {31'd0, bus.op_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd1);

    for (int k = 0; k < 6; k++) begin
      run_frame(tbl[k]);
      drain();
    end

    // Backpressure: second frame stalls only on its last word
    bus.op_ready = 1'b0;
    run_frame(mk(1'b0, 5, 1, 2, 3, 4, 5, 1, 2, 3, 4, 5));
    for (int i = 0; i < 4; i++) send(32'd21 + i, 1'b0);
    chk("bp_hold_x1", bus.x1, 32'd1);
    bus.s_data  = 32'd25;
    bus.s_valid = 1'b1;
    #1;
    chk("bp_s_ready_low", {31'd0, bus.s_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_op_valid_held", {31'd0, bus.op_valid}, 32'd1);
    chk("bp_hold_b", bus.b, 32'd5);
    chk("bp_busy", {31'd0, bus.busy}, 32'd1);
    bus.op_ready = 1'b1;
    bb = '{32'd21, 32'd22, 32'd23, 32'd24, 32'd25};
    sb.push_back(bb);
    #1;
    chk("bp_s_ready_high", {31'd0, bus.s_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    chk("b2b_op_valid", {31'd0, bus.op_valid}, 32'd1);
    chk("b2b_x1", bus.x1, 32'd21);
    drain();

    // Reset mid-frame discards partial data and weights
    for (int i = 0; i < 3; i++) send(32'd99 - i, 1'b0);
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_w1", bus.w1, 32'd0);
    chk("mid_rst_x1", bus.x1, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_frame(mk(1'b1, 2, 6, 7, 0, 0, 0, 6, 7, 0, 0, 0));
    drain();
    run_frame(mk(1'b0, 5, 1, 2, 3, 4, 5, 1, 2, 3, 4, 5));
    drain();

    // clear mid-frame and clear coincident with the last word
    run_frame(tbl[5]);
    drain();
    send(32'd50, 1'b0);
    send(32'd51, 1'b0);
    clear_cycle(1'b1, 32'd52);
    chk("clr_busy", {31'd0, bus.busy}, 32'd0);
    chk("clr_op_valid", {31'd0, bus.op_valid}, 32'd0);
    chk("clr_x1_kept", bus.x1, 32'd5);
    send(32'd60, 1'b0);
    send(32'd61, 1'b0);
    send(32'd2, 1'b0);
    send(32'd4, 1'b0);
    clear_cycle(1'b1, 32'd99);
    chk("clr_last_op_valid", {31'd0, bus.op_valid}, 32'd0);
    chk("clr_last_busy", {31'd0, bus.busy}, 32'd0);
    chk("clr_last_b_kept", bus.b, -32'sd7);
    run_frame(mk(1'b1, 2, 7, 8, 0, 0, 0, 7, 8, 2, 4, -32'sd7));
    drain();

    // clear drops a pending bundle
    bus.op_ready = 1'b0;
    send(32'd1, 1'b1);
    send(32'd2, 1'b0);
    chk("pend_op_valid", {31'd0, bus.op_valid}, 32'd1);
    clear_cycle(1'b0, 32'd0);
    chk("clr_drop_op_valid", {31'd0, bus.op_valid}, 32'd0);
    bus.op_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/neuron_operand_loader.md
# neuron_operand_loader

Stream-to-parallel operand loader that sits directly upstream of the 2-input neuron. It accepts 32-bit signed words one per handshake (x1, x2, w1, w2, b) and assembles them into a complete operand set. It presents that set as a held, registered bundle with a valid/ready handshake, so the combinational neuron always sees stable operands. A weight-reuse mode lets a frame carry only x1, x2 while the last-loaded w1, w2, b are retained.

## Interface
- DATA_W, 32, width of every data word and operand (two's-complement signed)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- s_data  input  DATA_W  incoming operand word
- s_valid  input  1  s_data valid
- s_ready  output  1  loader accepts s_data this cycle
- reuse_w  input  1  frame mode; sampled only with word 0 of a frame
- clear  input  1  synchronous abort of the current frame
- x1, x2, w1, w2, b  output  DATA_W each  registered operand bundle to the neuron
- op_valid  output  1  bundle complete and stable
- op_ready  input  1  neuron side consumes bundle
- busy  output  1  frame partially loaded (word counter != 0)

## Operation
- Accept: a word is taken on a rising edge when s_valid && s_ready.
- Word counter `idx`, 0..4, and sticky `mode_reuse` register.
  - Word 0 sets `mode_reuse = reuse_w`.
  - Full frame order: idx0 x1, idx1 x2, idx2 w1, idx3 w2, idx4 b. Last index is 4.
  - Reuse frame order: idx0 x1, idx1 x2. Last index is 1.
  - Accepting the last word returns idx to 0. Otherwise idx increments.
- Staging registers st_x1, st_x2, st_w1, st_w2, st_b capture the words.
  - st_w1, st_w2, st_b are written only by full frames. They persist across reuse frames, clear, and frames, and are cleared only by reset.
- Commit on acceptance of the last word:
  - Output regs load from staging.
  - The last word itself comes directly from s_data (b for full, x2 for reuse).
  - Reuse frames load w1, w2, b from the staged weights.
  - op_valid is set.
- Output slot:
  - op_valid clears on op_valid && op_ready unless a commit happens the same edge; in that case it stays 1 with new data.
  - Outputs must not change while op_valid && !op_ready.
- s_ready = !(at_last_index && op_valid && !op_ready).
  - This path is combinational from op_ready and must be documented for integration.
  - Non-last words are never stalled.
- clear (synchronous, highest priority after reset):
  - Sets idx=0 and op_valid=0; s_ready is ignored that cycle and any word on s_data is dropped.
  - Staged and output data are not modified.
- busy = (idx != 0).
- Arithmetic: no computation; data passes bit-exact. Signedness is preserved by the consumer.

## Timing
- Reset values:
  - Outputs: x1=x2=w1=w2=b=0, op_valid=0, busy=0.
  - Internal: idx=0, mode_reuse=0, staging regs=0.
  - s_ready=1 after reset (with clear low).
- Latency: op_valid rises on the edge that accepts the last word, i.e. visible the cycle after that handshake.
- Throughput: one word per cycle.
  - Full frames: one bundle per 5 cycles.
  - Reuse frames: one bundle per 2 cycles, with op_ready held high.
- Back-to-back: consuming bundle N and accepting the last word of bundle N+1 on the same edge yields op_valid continuously high with N+1 data.
- Boundaries:
  - reuse_w is ignored at idx != 0.
  - Reuse with no prior full frame presents w1=w2=b=0.
  - Reset mid-frame discards partial data and weights.
  - clear mid-frame keeps weights and restarts at x1.
  - clear coincident with a last-word handshake: clear wins, no commit.

## Test plan
- Full frame 5, -3, 2, 4, -7 with op_ready=1 -> op_valid one cycle after 5th accept; bundle x1=5, x2=-3, w1=2, w2=4, b=-7; busy high during idx 1..4.
- Reuse frame (reuse_w=1) 10, 20 after the frame above -> bundle x1=10, x2=20, w1=2, w2=4, b=-7 after 2 accepts.
- Backpressure: op_ready=0, full frame then second frame streamed -> s_ready low only at idx4 of the second frame; first bundle held unchanged; raising op_ready commits the second bundle on the same edge, op_valid stays 1.
- Reset mid-frame after 3 words -> all outputs 0, idx=0; the next 5 words 1..5 form bundle 1, 2, 3, 4, 5.
- clear after 2 words of a full frame following a loaded frame (w1=2, w2=4, b=-7) -> idx=0, op_valid=0; a reuse frame 7, 8 then yields 7, 8, 2, 4, -7.
- Sign passthrough: words 0x80000000, 0xFFFFFFFF, 0x7FFFFFFF, 1, 0 -> identical bits on x1..b.
